// File: rtl/mux7_rr_sched.sv
// mux7_rr_sched: round-robin scheduler that shares a 7:1 bit mux among up to
// seven requesters. Grant, select and grant_valid are registered. data_out is a
// combinational path from data_in through the mux.
// Optional macro MUX_SCHED_TIMEOUT_EN: after HOLD_MAX consecutive grant cycles,
// the owner is preempted in favour of the next waiting requester.

module mux7to1 (
  input  logic [6:0] data_in,
  input  logic [2:0] sel,
  output logic       out
);
  // Pick one data bit. The unused code 7 yields 0.
  always_comb begin
    out = 1'b0;
    if (sel < 3'd7) out = data_in[sel];
  end
endmodule

module mux7_rr_sched #(
  parameter int unsigned N_REQ    = 7,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] req,
  input  logic [6:0] data_in,
  output logic [6:0] grant,
  output logic [2:0] sel,
  output logic       grant_valid,
  output logic       data_out
);
  localparam int unsigned NUM_LINES = 7;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned CNT_W     = 8;
  localparam logic [NUM_LINES-1:0] REQ_MASK = NUM_LINES'((1 << N_REQ) - 1);
`ifdef MUX_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
`endif

  // Reject illegal configurations at elaboration time
  if (N_REQ < 2 || N_REQ > 7 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_cfg
    $error("mux7_rr_sched: N_REQ must be 2..7 and HOLD_MAX 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     last, last_nxt, sel_nxt, win_idx, cand;
  logic [NUM_LINES-1:0] valid_req, others, grant_nxt;
  logic [CNT_W-1:0]     hold_cnt, hold_nxt;
  logic                 valid_nxt, win_found, owner_req, take_win, mux_bit;

  // Requests above N_REQ are ignored. The current owner is excluded from the search.
  assign valid_req = req & REQ_MASK;
  assign others    = valid_req & ~grant;
  assign owner_req = valid_req[sel];

  // Round-robin winner search: first requester found from last+1, wrapping modulo N_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = SEL_W'((int'(last) + i) % int'(N_REQ));
      if (!win_found && others[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    valid_nxt = grant_valid;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    take_win  = 1'b0;

    unique case (state)
      IDLE: take_win = win_found;
      GRANT: begin
        if (owner_req) begin
`ifdef MUX_SCHED_TIMEOUT_EN
          // At the hold limit, preempt if someone waits, otherwise stay saturated
          if (hold_cnt >= HOLD_LIM) take_win = win_found;
          else                      hold_nxt = hold_cnt + CNT_W'(1);
`else
          if (hold_cnt != '1) hold_nxt = hold_cnt + CNT_W'(1);
`endif
        end else if (win_found) begin
          take_win = 1'b1;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
          valid_nxt = 1'b0;
          hold_nxt  = '0;
        end
      end
    endcase

    if (take_win) begin
      state_nxt = GRANT;
      grant_nxt = NUM_LINES'(1) << win_idx;
      sel_nxt   = win_idx;
      valid_nxt = 1'b1;
      last_nxt  = win_idx;
      hold_nxt  = CNT_W'(1);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      sel         <= '0;
      grant_valid <= 1'b0;
      last        <= SEL_W'(N_REQ - 1);
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      sel         <= sel_nxt;
      grant_valid <= valid_nxt;
      last        <= last_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

  mux7to1 u_mux (
    .data_in (data_in),
    .sel     (sel),
    .out     (mux_bit)
  );

  assign data_out = mux_bit & grant_valid;

endmodule

// File: tb/tb_mux7_rr_sched.sv
// Testbench for mux7_rr_sched (N_REQ=7, HOLD_MAX=3). Expected grant/sel/valid per
// cycle are queued as stimulus is applied and compared against captured outputs.
// Build with +define+MUX_SCHED_TIMEOUT_EN to exercise the preemption variant.

module tb_mux7_rr_sched;

  typedef struct packed {
    logic [6:0] grant;
    logic [2:0] sel;
    logic       valid;
  } exp_t;

  typedef struct packed {
    logic [6:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       dout;
    logic [6:0] din;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] req;
  logic [6:0] data_in;
  logic [6:0] grant;
  logic [2:0] sel;
  logic       grant_valid;
  logic       data_out;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mux7_rr_sched #(.N_REQ(7), .HOLD_MAX(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .sel         (sel),
    .grant_valid (grant_valid),
    .data_out    (data_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of stimulus, queue the expected post-edge outputs, capture actual ones
  task automatic drive(input logic rst, input logic [6:0] r,
                       input logic [6:0] g, input logic [2:0] s, input logic v);
    reset   = rst;
    req     = r;
    data_in = 7'($urandom);
    exp_q.push_back({g, s, v});
    @(posedge clock);
    #1;
    obs_q.push_back({grant, sel, grant_valid, data_out, data_in});
  endtask

  task automatic test_reset();
    exp_t e; obs_t o; logic ed; int k;
    drive(1'b1, 7'h7F, 7'h00, 3'd0, 1'b0);
    drive(1'b1, 7'h7F, 7'h00, 3'd0, 1'b0);
    drive(1'b0, 7'h7F, 7'h01, 3'd0, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.grant, o.sel, o.valid} !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
                 k, o.grant, o.sel, o.valid, e.grant, e.sel, e.valid);
      end
      ed = e.valid ? o.din[e.sel] : 1'b0;
      n_checks++;
      if (o.dout !== ed) begin
        n_fail++;
        $display("FAIL reset data_out step %0d: got %b, expected %b", k, o.dout, ed);
      end
      k++;
    end
  endtask

  task automatic test_round_robin();
    exp_t e; obs_t o; logic ed; int k; int nxt;
    drive(1'b1, 7'h00, 7'h00, 3'd0, 1'b0);
    drive(1'b0, 7'h7F, 7'h01, 3'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      nxt = (i + 1) % 7;
      drive(1'b0, 7'h7F & ~(7'h01 << i), 7'h01 << nxt, 3'(nxt), 1'b1);
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.grant, o.sel, o.valid} !== e) begin
        n_fail++;
        $display("FAIL round_robin step %0d: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
                 k, o.grant, o.sel, o.valid, e.grant, e.sel, e.valid);
      end
      ed = e.valid ? o.din[e.sel] : 1'b0;
      n_checks++;
      if (o.dout !== ed) begin
        n_fail++;
        $display("FAIL round_robin data_out step %0d: got %b, expected %b", k, o.dout, ed);
      end
      k++;
    end
  endtask

  task automatic test_single_release();
    exp_t e; obs_t o; logic ed; int k;
    drive(1'b1, 7'h00, 7'h00, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 7'h10, 7'h10, 3'd4, 1'b1);
    // data_out follows data_in with no clock while granted
    data_in = 7'h10; #1;
    n_checks++;
    if (data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_passthru_hi: got data_out=%b, expected 1", data_out);
    end
    data_in = 7'h6F; #1;
    n_checks++;
    if (data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_passthru_lo: got data_out=%b, expected 0", data_out);
    end
    drive(1'b0, 7'h00, 7'h00, 3'd4, 1'b0);
    drive(1'b0, 7'h00, 7'h00, 3'd4, 1'b0);
    data_in = 7'h7F; #1;
    n_checks++;
    if (data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle_gate: got data_out=%b, expected 0", data_out);
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.grant, o.sel, o.valid} !== e) begin
        n_fail++;
        $display("FAIL single_release step %0d: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
                 k, o.grant, o.sel, o.valid, e.grant, e.sel, e.valid);
      end
      ed = e.valid ? o.din[e.sel] : 1'b0;
      n_checks++;
      if (o.dout !== ed) begin
        n_fail++;
        $display("FAIL single_release data_out step %0d: got %b, expected %b", k, o.dout, ed);
      end
      k++;
    end
  endtask

  task automatic test_wrap_skip();
    exp_t e; obs_t o; logic ed; int k;
    drive(1'b1, 7'h00, 7'h00, 3'd0, 1'b0);
    drive(1'b0, 7'h20, 7'h20, 3'd5, 1'b1);
    drive(1'b0, 7'h05, 7'h01, 3'd0, 1'b1);
    drive(1'b0, 7'h04, 7'h04, 3'd2, 1'b1);
    drive(1'b0, 7'h00, 7'h00, 3'd2, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.grant, o.sel, o.valid} !== e) begin
        n_fail++;
        $display("FAIL wrap_skip step %0d: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
                 k, o.grant, o.sel, o.valid, e.grant, e.sel, e.valid);
      end
      ed = e.valid ? o.din[e.sel] : 1'b0;
      n_checks++;
      if (o.dout !== ed) begin
        n_fail++;
        $display("FAIL wrap_skip data_out step %0d: got %b, expected %b", k, o.dout, ed);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; obs_t o; logic ed; int k;
    drive(1'b1, 7'h00, 7'h00, 3'd0, 1'b0);
    drive(1'b0, 7'h03, 7'h01, 3'd0, 1'b1);
    drive(1'b0, 7'h02, 7'h02, 3'd1, 1'b1);
    drive(1'b0, 7'h03, 7'h02, 3'd1, 1'b1);
    drive(1'b0, 7'h01, 7'h01, 3'd0, 1'b1);
    drive(1'b0, 7'h00, 7'h00, 3'd0, 1'b0);
    drive(1'b0, 7'h01, 7'h01, 3'd0, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.grant, o.sel, o.valid} !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
                 k, o.grant, o.sel, o.valid, e.grant, e.sel, e.valid);
      end
      ed = e.valid ? o.din[e.sel] : 1'b0;
      n_checks++;
      if (o.dout !== ed) begin
        n_fail++;
        $display("FAIL back_to_back data_out step %0d: got %b, expected %b", k, o.dout, ed);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    exp_t e; obs_t o; logic ed; int k;
    drive(1'b1, 7'h00, 7'h00, 3'd0, 1'b0);
`ifdef MUX_SCHED_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      if (((i / 3) % 2) == 0) drive(1'b0, 7'h03, 7'h01, 3'd0, 1'b1);
      else                    drive(1'b0, 7'h03, 7'h02, 3'd1, 1'b1);
    end
`else
    for (int i = 0; i < 300; i++) drive(1'b0, 7'h03, 7'h01, 3'd0, 1'b1);
`endif
    drive(1'b1, 7'h00, 7'h00, 3'd0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 7'h01, 7'h01, 3'd0, 1'b1);
`ifdef MUX_SCHED_TIMEOUT_EN
    drive(1'b0, 7'h03, 7'h02, 3'd1, 1'b1);
`else
    drive(1'b0, 7'h03, 7'h01, 3'd0, 1'b1);
`endif
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.grant, o.sel, o.valid} !== e) begin
        n_fail++;
        $display("FAIL timeout step %0d: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
                 k, o.grant, o.sel, o.valid, e.grant, e.sel, e.valid);
      end
      ed = e.valid ? o.din[e.sel] : 1'b0;
      n_checks++;
      if (o.dout !== ed) begin
        n_fail++;
        $display("FAIL timeout data_out step %0d: got %b, expected %b", k, o.dout, ed);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_grant();
    exp_t e; obs_t o; logic ed; int k;
    drive(1'b1, 7'h00, 7'h00, 3'd0, 1'b0);
    drive(1'b0, 7'h08, 7'h08, 3'd3, 1'b1);
    drive(1'b0, 7'h08, 7'h08, 3'd3, 1'b1);
    drive(1'b1, 7'h08, 7'h00, 3'd0, 1'b0);
    drive(1'b0, 7'h08, 7'h08, 3'd3, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.grant, o.sel, o.valid} !== e) begin
        n_fail++;
        $display("FAIL reset_mid_grant step %0d: got grant=%h sel=%0d valid=%b, expected grant=%h sel=%0d valid=%b",
                 k, o.grant, o.sel, o.valid, e.grant, e.sel, e.valid);
      end
      ed = e.valid ? o.din[e.sel] : 1'b0;
      n_checks++;
      if (o.dout !== ed) begin
        n_fail++;
        $display("FAIL reset_mid_grant data_out step %0d: got %b, expected %b", k, o.dout, ed);
      end
      k++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    data_in = '0;
    test_reset();
    test_round_robin();
    test_single_release();
    test_wrap_skip();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
